// File: rtl/alu_unit.sv
// alu_unit: 8-bit add/sub with carry/zero flags; optional shift-add multiplier when MULT_EN is defined.
module alu_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       SU,
  input  logic       EO,
  input  logic       FI,
  input  logic       MS,
  output logic [7:0] alu_out,
  output logic       alu_oe,
  output logic       flag_c,
  output logic       flag_z,
  output logic       busy
);
  logic [8:0] sum;
  logic       cap, c_nx, z_nx;
  assign sum    = {1'b0, A} + {1'b0, SU ? ~B : B} + {8'b0, SU};
  assign alu_oe = EO;
`ifdef MULT_EN
  typedef enum logic [1:0] {IDLE, RUN, LO, HI} state_t;
  state_t      state, state_nx;
  logic [15:0] p, mcand;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  // A restart strobe in LO/HI takes priority over read-out advance
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = MS ? RUN : IDLE;
      RUN:     state_nx = cnt == 3'd7 ? LO : RUN;
      LO:      state_nx = MS ? RUN : EO ? HI : LO;
      default: state_nx = MS ? RUN : EO ? IDLE : HI;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      p      <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == RUN) begin
      p      <= mplier[0] ? p + mcand : p;
      mplier <= mplier >> 1;
      mcand  <= mcand << 1;
      cnt    <= cnt + 3'd1;
    end else if (MS) begin
      p      <= '0;
      mcand  <= {8'b0, A};
      mplier <= B;
      cnt    <= '0;
    end
  assign busy    = state == RUN;
  assign alu_out = state == LO ? p[7:0] : state == HI ? p[15:8] : sum[7:0];
  assign cap     = FI && state != RUN;
  assign c_nx    = state == IDLE ? sum[8] : |p[15:8];
  assign z_nx    = state == IDLE ? ~|sum[7:0] : ~|p;
`else
  logic unused_ms;
  assign unused_ms = MS;
  assign busy      = 1'b0;
  assign alu_out   = sum[7:0];
  assign cap       = FI;
  assign c_nx      = sum[8];
  assign z_nx      = ~|sum[7:0];
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (cap) begin
      flag_c <= c_nx;
      flag_z <= z_nx;
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: table-driven adder/flag checks with a flag scoreboard, plus multiplier sequences under MULT_EN.
module tb_alu_unit;
  logic       clk = 0, rst = 0;
  logic [7:0] A = 8'h12, B = 8'h34;
  logic       SU = 0, EO = 0, FI = 0, MS = 0;
  logic [7:0] alu_out;
  logic       alu_oe, flag_c, flag_z, busy;
  int         checks = 0, errors = 0;
  typedef struct {logic [7:0] a, b; logic su; logic [7:0] y; logic c, z;} vec_t;
  vec_t vecs[7];
  vec_t sb[$];
  vec_t e;
  always #5 clk = ~clk;
  alu_unit dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .SU(SU), .EO(EO), .FI(FI), .MS(MS),
    .alu_out(alu_out), .alu_oe(alu_oe), .flag_c(flag_c), .flag_z(flag_z), .busy(busy)
  );
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
`ifdef MULT_EN
  task automatic mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int n;
    A = a; B = b; SU = 0; MS = 1;
    step;
    MS = 0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      step;
    end
    chk("busy_cycles", 16'(n), 16'd8);
    chk("prod_lo", {8'b0, alu_out}, {8'b0, p[7:0]});
    FI = 1;
    step;
    FI = 0;
    chk("mul_c", {15'b0, flag_c}, {15'b0, p[15:8] != 8'd0});
    chk("mul_z", {15'b0, flag_z}, {15'b0, p == 16'd0});
    EO = 1;
    step;
    EO = 0;
    chk("prod_hi", {8'b0, alu_out}, {8'b0, p[15:8]});
    EO = 1;
    step;
    EO = 0;
    chk("back_to_add", {8'b0, alu_out}, {8'b0, 8'(a + b)});
  endtask
`endif
  initial begin
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h03, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'h02, 8'h03, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    #1;
    chk("rst_busy", {15'b0, busy}, 16'd0);
    chk("rst_c", {15'b0, flag_c}, 16'd0);
    chk("rst_z", {15'b0, flag_z}, 16'd0);
    chk("rst_out", {8'b0, alu_out}, 16'h0046);
    #2 rst = 1;
    step;
    foreach (vecs[i]) begin
      A = vecs[i].a; B = vecs[i].b; SU = vecs[i].su; FI = 1; EO = i[0];
      #1;
      chk("sum", {8'b0, alu_out}, {8'b0, vecs[i].y});
      chk("oe", {15'b0, alu_oe}, {15'b0, EO});
      sb.push_back(vecs[i]);
      step;
      FI = 0; EO = 0;
      if (sb.size() == 0) chk("sb_empty", 16'd0, 16'd1);
      else begin
        e = sb.pop_front();
        chk("flag_c", {15'b0, flag_c}, {15'b0, e.c});
        chk("flag_z", {15'b0, flag_z}, {15'b0, e.z});
      end
    end
`ifdef MULT_EN
    mult(8'h0C, 8'h0D, 16'h009C);
    mult(8'h20, 8'h10, 16'h0200);
    A = 8'h11; B = 8'h22; MS = 1;
    step;
    MS = 0;
    step;
    step;
    step;
    #2 rst = 0;
    #1;
    chk("abort_busy", {15'b0, busy}, 16'd0);
    chk("abort_c", {15'b0, flag_c}, 16'd0);
    chk("abort_z", {15'b0, flag_z}, 16'd0);
    chk("abort_out", {8'b0, alu_out}, 16'h0033);
    #1 rst = 1;
    step;
    mult(8'h11, 8'h22, 16'h0242);
`else
    A = 8'h03; B = 8'h04; SU = 0; MS = 1;
    step;
    MS = 0;
    chk("nomul_busy", {15'b0, busy}, 16'd0);
    chk("nomul_out", {8'b0, alu_out}, 16'h0007);
    step;
    chk("nomul_busy2", {15'b0, busy}, 16'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
